// File: rtl/game_clock_core.sv
// game_clock_core: multi-player BCD game clock (chess-clock style).
// One BCD mm:ss counter per player; the active player's counter counts down
// once per PRESCALE enabled cycles while running. A counter reaching 00:00
// flags that player's timeout and freezes the game until the next LOAD.
// Optional feature macro: FISCHER_INC_EN adds INC_SEC seconds to the player
// who passes the turn, saturating at 99:59.
module game_clock_core #(
    parameter int N_PLAYERS = 2,
    parameter int PRESCALE  = 100000000,
    parameter int INC_SEC   = 5,
    localparam int AW = ($clog2(N_PLAYERS) < 1) ? 1 : $clog2(N_PLAYERS),
    localparam int PW = $clog2(PRESCALE)
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 CE,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 PASS,
    input  logic                 LOAD,
    input  logic [7:0]           PRESET_MIN,
    input  logic [7:0]           PRESET_SEC,
    input  logic [AW-1:0]        DISP_SEL,
    output logic [7:0]           disp_min,
    output logic [7:0]           disp_sec,
    output logic [AW-1:0]        active,
    output logic [N_PLAYERS-1:0] timeout,
    output logic [1:0]           state,
    output logic                 END
);

    // Parameter sanity: reject illegal configurations at elaboration.
    generate
        if (N_PLAYERS < 2 || N_PLAYERS > 8) begin : g_bad_players
            $error("game_clock_core: N_PLAYERS must be 2..8");
        end
        if (PRESCALE < 2) begin : g_bad_prescale
            $error("game_clock_core: PRESCALE must be >= 2");
        end
        if (INC_SEC < 0 || INC_SEC > 59) begin : g_bad_inc
            $error("game_clock_core: INC_SEC must be 0..59");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_END   = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          active_q, active_d;
    logic [N_PLAYERS-1:0]   timeout_q, timeout_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [7:0]             min_q [N_PLAYERS];
    logic [7:0]             sec_q [N_PLAYERS];
    logic [7:0]             min_d [N_PLAYERS];
    logic [7:0]             sec_d [N_PLAYERS];

    logic [7:0]             cur_min, cur_sec;
    logic [15:0]            dec_val;
    logic                   tick, stop_act, start_act, pass_act;

    // One-second BCD decrement with borrow; never called with 00:00.
    function automatic logic [15:0] bcd_dec(input logic [7:0] m, input logic [7:0] s);
        logic [7:0] mo, so;
        mo = m;
        so = s;
        if (s == 8'h00) begin
            so = 8'h59;
            if (m[3:0] == 4'd0) mo = {m[7:4] - 4'd1, 4'd9};
            else                mo = {m[7:4], m[3:0] - 4'd1};
        end else if (s[3:0] == 4'd0) begin
            so = {s[7:4] - 4'd1, 4'd9};
        end else begin
            so = {s[7:4], s[3:0] - 4'd1};
        end
        return {mo, so};
    endfunction

`ifdef FISCHER_INC_EN
    localparam logic [4:0] INC_T = 5'(INC_SEC / 10);
    localparam logic [4:0] INC_O = 5'(INC_SEC % 10);

    // BCD add of INC_SEC seconds with carry into minutes, saturating at 99:59.
    function automatic logic [15:0] bcd_inc(input logic [7:0] m, input logic [7:0] s);
        logic [4:0] ones, tens;
        logic [7:0] mo;
        logic       c1, c2;
        ones = {1'b0, s[3:0]} + INC_O;
        c1   = (ones >= 5'd10);
        if (c1) ones = ones - 5'd10;
        tens = {1'b0, s[7:4]} + INC_T + {4'd0, c1};
        c2   = (tens >= 5'd6);
        if (c2) tens = tens - 5'd6;
        mo = m;
        if (c2) begin
            if (m == 8'h99)          return 16'h9959;
            else if (m[3:0] == 4'd9) mo = {m[7:4] + 4'd1, 4'd0};
            else                     mo = {m[7:4], m[3:0] + 4'd1};
        end
        return {mo, tens[3:0], ones[3:0]};
    endfunction
`endif

    assign cur_min   = min_q[active_q];
    assign cur_sec   = sec_q[active_q];
    assign dec_val   = bcd_dec(cur_min, cur_sec);
    assign tick      = (state_q == S_RUN) && (presc_q == PW'(PRESCALE - 1));
    assign stop_act  = STOP && (state_q == S_RUN);
    assign start_act = START && (state_q == S_IDLE || state_q == S_PAUSE);
    assign pass_act  = PASS && (state_q == S_RUN);

    // Next-state: one prioritised action per enabled cycle.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        timeout_d = timeout_q;
        presc_d   = presc_q;
        for (int i = 0; i < N_PLAYERS; i++) begin
            min_d[i] = min_q[i];
            sec_d[i] = sec_q[i];
        end
        if (CE) begin
            if (LOAD) begin
                state_d   = S_IDLE;
                active_d  = '0;
                timeout_d = '0;
                presc_d   = '0;
                for (int i = 0; i < N_PLAYERS; i++) begin
                    min_d[i] = PRESET_MIN;
                    sec_d[i] = PRESET_SEC;
                end
            end else if (stop_act) begin
                state_d = S_PAUSE;
            end else if (start_act) begin
                state_d = S_RUN;
            end else if (pass_act) begin
                active_d = (active_q == AW'(N_PLAYERS - 1)) ? '0 : active_q + 1'b1;
                presc_d  = '0;
`ifdef FISCHER_INC_EN
                {min_d[active_q], sec_d[active_q]} = bcd_inc(cur_min, cur_sec);
`endif
            end else if (state_q == S_RUN) begin
                if (tick) begin
                    presc_d = '0;
                    if (cur_min == 8'h00 && cur_sec == 8'h00) begin
                        // Unloaded (reset) counters expire instead of wrapping.
                        timeout_d[active_q] = 1'b1;
                        state_d             = S_END;
                    end else begin
                        {min_d[active_q], sec_d[active_q]} = dec_val;
                        if (dec_val == 16'h0000) begin
                            timeout_d[active_q] = 1'b1;
                            state_d             = S_END;
                        end
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end else if (state_q == S_IDLE || state_q == S_END) begin
                presc_d = '0;
            end
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            active_q  <= '0;
            timeout_q <= '0;
            presc_q   <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            timeout_q <= timeout_d;
            presc_q   <= presc_d;
        end
    end

    // Per-channel time registers.
    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_chan
            // Channel gi mm:ss storage, cleared to 00:00 on reset.
            always_ff @(posedge CLK or posedge CLR) begin
                if (CLR) begin
                    min_q[gi] <= 8'h00;
                    sec_q[gi] <= 8'h00;
                end else begin
                    min_q[gi] <= min_d[gi];
                    sec_q[gi] <= sec_d[gi];
                end
            end
        end
    endgenerate

    // Display mux; out-of-range selections show 00:00.
    always_comb begin
        disp_min = 8'h00;
        disp_sec = 8'h00;
        if (int'(DISP_SEL) < N_PLAYERS) begin
            disp_min = min_q[DISP_SEL];
            disp_sec = sec_q[DISP_SEL];
        end
    end

    assign active  = active_q;
    assign timeout = timeout_q;
    assign state   = state_q;
    assign END     = (state_q == S_END);

endmodule

// File: doc/game_clock_core.md
GAME_CLOCK_CORE -- requirements
Module: game_clock_core

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2: number of player channels, legal range 2..8.
REQ-002 SHALL have parameter PRESCALE, default 100000000: number of CE-qualified CLK cycles per one-second tick, legal range 2 or more.
REQ-003 SHALL have parameter INC_SEC, default 5: Fischer increment in seconds, legal range 0..59; used only under FISCHER_INC_EN.
REQ-004 SHALL derive AW = max(1, clog2(N_PLAYERS)) for player-index widths.
REQ-005 SHALL have ports (name direction width meaning), clock and reset first:
- CLK  in  1  single system clock; all state updates on rising edge.
- CLR  in  1  asynchronous, active-high reset.
- CE  in  1  global clock enable; when low, all state holds.
- START  in  1  pulse; begins or resumes timing.
- STOP  in  1  pulse; pauses timing.
- PASS  in  1  pulse; active player ends turn.
- LOAD  in  1  pulse; loads preset time into every channel.
- PRESET_MIN  in  8  BCD minutes, 00..99.
- PRESET_SEC  in  8  BCD seconds, 00..59.
- DISP_SEL  in  AW  index of the channel to display.
- disp_min  out  8  BCD minutes of the selected channel.
- disp_sec  out  8  BCD seconds of the selected channel.
- active  out  AW  index of the running player.
- timeout  out  N_PLAYERS  per-channel flag, set when that channel reaches 00:00.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 END.
- END  out  1  high while state is END.

Function
REQ-006 SHALL sample all pulse inputs only on cycles where CE=1, one action per cycle.
REQ-007 SHALL apply priority LOAD > STOP > START > PASS > tick when inputs coincide.
REQ-008 SHALL transition: IDLE-START->RUN; RUN-STOP->PAUSE; PAUSE-START->RUN; RUN-timeout->END; any state-LOAD->IDLE.
REQ-009 SHALL, on LOAD, set every channel to PRESET_MIN:PRESET_SEC, clear timeout, set active=0, and clear the prescaler.
REQ-010 SHALL run the prescaler only in RUN, count 0..PRESCALE-1, and emit a tick on the wrap cycle.
REQ-011 SHALL hold the prescaler count in PAUSE and clear it in IDLE and END.
REQ-012 SHALL, on a tick, decrement the active channel by one second in BCD with borrow: x0 seconds become (x-1)9; 00 seconds become 59 with minutes decremented.
REQ-013 SHALL, when a decrement yields 00:00, set timeout[active] and enter END on the same edge; 00:00 SHALL never wrap to 99:59.
REQ-014 SHALL, on PASS in RUN, set active to (active+1) mod N_PLAYERS and clear the prescaler.
REQ-015 SHALL ignore PASS outside RUN.
REQ-016 SHALL, when PASS and a tick coincide, ignore the tick and perform the PASS.
REQ-017 SHALL, in END, freeze all channels and ignore START, STOP and PASS until LOAD.
REQ-018 SHALL drive disp_min and disp_sec combinationally from the DISP_SEL channel.
REQ-019 SHALL drive disp_min and disp_sec as 00 when DISP_SEL >= N_PLAYERS.
REQ-020 SHALL leave preset values outside BCD range as undefined behaviour, with no checking required.

Reset
REQ-021 SHALL, while CLR=1 and irrespective of CLK, force: all channels 00:00, timeout=0, active=0, state=IDLE, END=0, prescaler=0.
REQ-022 SHALL, after reset is released mid-game, require LOAD before meaningful timing; START from IDLE with 00:00 times SHALL enter END at the first tick.

Configuration
REQ-023 SHALL use macro FISCHER_INC_EN.
REQ-024 SHALL, when FISCHER_INC_EN is defined, add INC_SEC seconds to the outgoing channel on every accepted PASS, in BCD with carry into minutes, saturating at 99:59.
REQ-025 SHALL, when FISCHER_INC_EN is undefined, implement no increment logic, ignore INC_SEC, and leave PASS changing only active and the prescaler.

Verification
REQ-026 Bench SHALL cover LOAD 05:00, START, then PRESCALE CE cycles -> channel0 = 04:59, channel1 = 05:00.
REQ-027 Bench SHALL cover channel0 at 01:00, one tick -> 00:59; channel0 at 00:10, one tick -> 00:09.
REQ-028 Bench SHALL cover channel0 at 00:01, one tick -> 00:00, timeout=01, END=1, state=11; subsequent PASS/START -> no change.
REQ-029 Bench SHALL cover N_PLAYERS=3, RUN, three PASS pulses -> active 1, 2, 0; STOP mid-second, START -> remaining prescaler count preserved.
REQ-030 Bench SHALL cover FISCHER_INC_EN, INC_SEC=5, channel0 at 00:58, PASS -> 01:03; at 99:57, PASS -> 99:59.
REQ-031 Bench SHALL cover asserting CLR mid-RUN between clock edges -> outputs reset immediately; LOAD and START coincident -> IDLE with presets loaded.
